// File: rtl/mat_result_checker.sv
// Lock-step sweep of the result and golden memories: counts mismatches, records the first
// failing address and reports done/pass. Define CHK_TOLERANCE_EN to add a tolerance port (tol).
module mat_result_checker #(
  parameter int DATA_W = 21,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] dut_data,
  input  logic [DATA_W-1:0] gold_data,
`ifdef CHK_TOLERANCE_EN
  input  logic [DATA_W-1:0] tol,
`endif
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              first_err_vld
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [2:0]      DRAIN_LAST = 3'(RD_LAT - 1);

  logic [1:0]              state_q, state_d;
  logic [ADDR_W:0]         len_q, len_d;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
  logic [2:0]              drain_q, drain_d;
  logic [CNT_W-1:0]        err_q, err_d;
  logic [ADDR_W-1:0]       first_addr_q, first_addr_d;
  logic                    first_vld_q, first_vld_d;
  logic [RD_LAT-1:0]       vld_q;
  logic [RD_LAT-1:0][ADDR_W-1:0] paddr_q;
  logic                    mismatch;
  logic                    cmp_vld;
  logic [ADDR_W-1:0]       cmp_addr;

  assign cmp_vld  = vld_q[RD_LAT-1];
  assign cmp_addr = paddr_q[RD_LAT-1];

`ifdef CHK_TOLERANCE_EN
  logic [DATA_W-1:0] tol_q, tol_d;
  logic [DATA_W-1:0] abs_diff;

  always_comb begin
    abs_diff = (dut_data >= gold_data) ? (dut_data - gold_data) : (gold_data - dut_data);
    mismatch = abs_diff > tol_q;
  end
`else
  assign mismatch = dut_data != gold_data;
`endif

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    drain_d      = drain_q;
    err_d        = err_q;
    first_addr_d = first_addr_q;
    first_vld_d  = first_vld_q;
`ifdef CHK_TOLERANCE_EN
    tol_d        = tol_q;
`endif

    // The compare pipeline is empty whenever start can be accepted, so the two never collide.
    if (cmp_vld && mismatch) begin
      if (err_q != {CNT_W{1'b1}}) err_d = err_q + 1'b1;
      if (!first_vld_q) begin
        first_addr_d = cmp_addr;
        first_vld_d  = 1'b1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_d        = (len > MAX_LEN) ? MAX_LEN : len;
          err_d        = '0;
          first_addr_d = '0;
          first_vld_d  = 1'b0;
          rd_addr_d    = '0;
`ifdef CHK_TOLERANCE_EN
          tol_d        = tol;
`endif
          if (len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            rd_en_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if ({1'b0, rd_addr_q} == len_q - 1'b1) begin
          state_d   = S_DRAIN;
          drain_d   = '0;
          rd_addr_d = '0;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      default: begin
        // DRAIN: the last read's data is compared in the final drain cycle.
        if (drain_q == DRAIN_LAST) state_d = S_DONE;
        else                        drain_d = drain_q + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      drain_q      <= '0;
      err_q        <= '0;
      first_addr_q <= '0;
      first_vld_q  <= 1'b0;
      vld_q        <= '0;
      paddr_q      <= '0;
`ifdef CHK_TOLERANCE_EN
      tol_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      drain_q      <= drain_d;
      err_q        <= err_d;
      first_addr_q <= first_addr_d;
      first_vld_q  <= first_vld_d;
`ifdef CHK_TOLERANCE_EN
      tol_q        <= tol_d;
`endif
      vld_q[0]     <= rd_en_q;
      paddr_q[0]   <= rd_addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]   <= vld_q[i-1];
        paddr_q[i] <= paddr_q[i-1];
      end
    end
  end

  assign rd_en          = rd_en_q;
  assign rd_addr        = rd_addr_q;
  assign busy           = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign pass           = (state_q == S_DONE) && (err_q == '0);
  assign err_cnt        = err_q;
  assign first_err_addr = first_addr_q;
  assign first_err_vld  = first_vld_q;

endmodule

// File: tb/tb_mat_result_checker.sv
// Self-checking bench for mat_result_checker: a default instance (RD_LAT=1) and a small
// saturation instance (RD_LAT=3, CNT_W=4, 32 words), checked against a word-by-word model.
module tb_mat_result_checker;
  localparam int DW  = 21;
  localparam int AW  = 10;
  localparam int AWB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b;
  logic [AW:0]  len_a;
  logic [AWB:0] len_b;

  logic          rd_en_a, busy_a, done_a, pass_a, fvld_a;
  logic [AW-1:0] rd_addr_a, faddr_a;
  logic [15:0]   err_a;
  logic [DW-1:0] dd_a, gd_a;

  logic           rd_en_b, busy_b, done_b, pass_b, fvld_b;
  logic [AWB-1:0] rd_addr_b, faddr_b;
  logic [3:0]     err_b;
  logic [DW-1:0]  dp_b [3];
  logic [DW-1:0]  gp_b [3];

`ifdef CHK_TOLERANCE_EN
  logic [DW-1:0] tol_a, tol_b;
`endif

  logic [DW-1:0] mem_dut  [1024];
  logic [DW-1:0] mem_gold [1024];

  int tests = 0;
  int fails = 0;

  mat_result_checker #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .len(len_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .dut_data(dd_a), .gold_data(gd_a),
`ifdef CHK_TOLERANCE_EN
    .tol(tol_a),
`endif
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_err_addr(faddr_a), .first_err_vld(fvld_a)
  );

  mat_result_checker #(.DATA_W(DW), .ADDR_W(AWB), .RD_LAT(3), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .len(len_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .dut_data(dp_b[2]), .gold_data(gp_b[2]),
`ifdef CHK_TOLERANCE_EN
    .tol(tol_b),
`endif
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_err_addr(faddr_b), .first_err_vld(fvld_b)
  );

  // Memory models: garbage on idle cycles so a misaligned compare shows up as errors.
  always @(posedge clk) begin
    dd_a <= rd_en_a ? mem_dut[rd_addr_a]  : DW'($urandom);
    gd_a <= rd_en_a ? mem_gold[rd_addr_a] : DW'($urandom);
    dp_b[0] <= rd_en_b ? mem_dut[{5'd0, rd_addr_b}]  : DW'($urandom);
    gp_b[0] <= rd_en_b ? mem_gold[{5'd0, rd_addr_b}] : DW'($urandom);
    dp_b[1] <= dp_b[0];
    gp_b[1] <= gp_b[0];
    dp_b[2] <= dp_b[1];
    gp_b[2] <= gp_b[1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill_same();
    for (int i = 0; i < 1024; i++) begin
      mem_gold[i] = DW'($urandom);
      mem_dut[i]  = mem_gold[i];
    end
  endtask

  // One sweep on instance sel (0 = default, 1 = small) with the whole result checked against
  // a word-by-word reference; mid>0 pulses start again in that cycle of the sweep.
  task automatic run(input string name, input bit sel, input int len_v, input int mid, input int tol_v);
    int depth, lat, cmax, eff, cnt, first, cyc, n_rd, addr_bad, bound, d, a, g;
    logic r_en, dn;
    logic [63:0] r_addr;
    depth = sel ? 32 : 1024;
    lat   = sel ? 3 : 1;
    cmax  = sel ? 15 : 65535;
    eff   = (len_v > depth) ? depth : len_v;
    cnt = 0;
    first = -1;
    for (int i = 0; i < eff; i++) begin
      a = int'(mem_dut[i]);
      g = int'(mem_gold[i]);
      d = (a > g) ? a - g : g - a;
      if (d > tol_v) begin
        if (cnt < cmax) cnt++;
        if (first < 0) first = i;
      end
    end
`ifdef CHK_TOLERANCE_EN
    tol_a = DW'(tol_v);
    tol_b = DW'(tol_v);
`endif
    if (sel) begin len_b = (AWB+1)'(len_v); start_b = 1'b1; end
    else     begin len_a = (AW+1)'(len_v);  start_a = 1'b1; end
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    cyc = 1;
    n_rd = 0;
    addr_bad = 0;
    bound = eff + lat + 20;
    dn = 1'b0;
    while (cyc <= bound) begin
      dn     = sel ? done_b : done_a;
      r_en   = sel ? rd_en_b : rd_en_a;
      r_addr = sel ? 64'(rd_addr_b) : 64'(rd_addr_a);
      if (dn) break;
      if (r_en) begin
        if (r_addr != 64'(n_rd)) addr_bad++;
        n_rd++;
      end
      if (cyc == mid) begin
        if (sel) start_b = 1'b1; else start_a = 1'b1;
      end
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
      cyc++;
    end
    check({name, " done_seen"},  64'(dn), 64'd1);
    check({name, " done_cycle"}, 64'(cyc), 64'(eff + (eff == 0 ? 0 : lat) + 1));
    check({name, " rd_cycles"},  64'(n_rd), 64'(eff));
    check({name, " rd_addr_seq"}, 64'(addr_bad), 64'd0);
    check({name, " busy"},     sel ? 64'(busy_b) : 64'(busy_a), 64'd0);
    check({name, " err_cnt"},  sel ? 64'(err_b) : 64'(err_a), 64'(cnt));
    check({name, " first_vld"}, sel ? 64'(fvld_b) : 64'(fvld_a), 64'(first >= 0));
    check({name, " first_addr"}, sel ? 64'(faddr_b) : 64'(faddr_a), 64'(first < 0 ? 0 : first));
    check({name, " pass"},     sel ? 64'(pass_b) : 64'(pass_a), 64'(cnt == 0));
    $display("[TB] %s len=%0d cycles=%0d err_cnt=%0d first=%0d pass=%0b",
             name, len_v, cyc, sel ? int'(err_b) : int'(err_a),
             sel ? int'(faddr_b) : int'(faddr_a), sel ? pass_b : pass_a);
  endtask

  initial begin
    int wait_cyc;
    rst = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    len_a = '0;
    len_b = '0;
`ifdef CHK_TOLERANCE_EN
    tol_a = '0;
    tol_b = '0;
`endif
    fill_same();
    repeat (3) tick();
    check("reset_outputs_a", 64'({rd_en_a, rd_addr_a, busy_a, done_a, pass_a, err_a, faddr_a, fvld_a}), 64'd0);
    check("reset_outputs_b", 64'({rd_en_b, rd_addr_b, busy_b, done_b, pass_b, err_b, faddr_b, fvld_b}), 64'd0);
    rst = 1'b1;
    tick();

    // Reset mid-sweep at address 300, then a short clean sweep.
    len_a = 11'd1024;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_cyc = 0;
    while (!(rd_en_a && rd_addr_a == 10'd300) && wait_cyc < 2000) begin
      tick();
      wait_cyc++;
    end
    check("mid_reset_reached_300", 64'(rd_addr_a), 64'd300);
    rst = 1'b0;
    tick();
    check("mid_reset_outputs", 64'({rd_en_a, rd_addr_a, busy_a, done_a, pass_a, err_a, faddr_a, fvld_a}), 64'd0);
    tick();
    check("mid_reset_held", 64'({rd_en_a, busy_a, done_a, pass_a}), 64'd0);
    rst = 1'b1;
    tick();
    run("after_reset_len4", 1'b0, 4, 0, 0);

    fill_same();
    run("clean_1024", 1'b0, 1024, 0, 0);

    mem_gold[5]    = mem_gold[5] ^ 21'h1;
    mem_gold[17]   = mem_gold[17] ^ 21'h100000;
    mem_gold[1023] = mem_gold[1023] ^ 21'h0F0F0;
    run("injected_3", 1'b0, 1024, 0, 0);

    run("len0", 1'b0, 0, 0, 0);

    fill_same();
    mem_dut[0] = mem_dut[0] ^ 21'h4;
    run("len1_mismatch", 1'b0, 1, 0, 0);

    fill_same();
    mem_dut[9] = mem_dut[9] + 21'd1;
    run("len16_mid_start", 1'b0, 16, 6, 0);

    fill_same();
    mem_dut[1023] = ~mem_dut[1023];
    run("clamp_1500", 1'b0, 1500, 0, 0);

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 1024; i++) begin
        mem_gold[i] = DW'($urandom);
        mem_dut[i]  = ($urandom_range(0, 47) == 0) ? (mem_gold[i] ^ DW'($urandom_range(1, 2097151)))
                                                    : mem_gold[i];
      end
      run($sformatf("random_%0d", r), 1'b0, int'($urandom_range(0, 1100)), 0, 0);
    end

    for (int i = 0; i < 32; i++) mem_dut[i] = ~mem_gold[i];
    run("sat_lat3", 1'b1, 32, 0, 0);

    fill_same();
    mem_dut[20] = mem_dut[20] ^ 21'h2;
    run("lat3_single", 1'b1, 24, 10, 0);

`ifdef CHK_TOLERANCE_EN
    fill_same();
    mem_dut[0] = 21'd100; mem_gold[0] = 21'd102;
    mem_dut[1] = 21'd100; mem_gold[1] = 21'd97;
    mem_dut[2] = 21'd0;   mem_gold[2] = 21'd3;
    run("tolerance_2", 1'b0, 3, 0, 2);
    check("tolerance_err_cnt", 64'(err_a), 64'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mat_result_checker.md
Name: mat_result_checker

Overview:
- Hardware self-check unit for the matrix-multiply datapath. After a compute run it sweeps the result memory (MEM_C) and a golden memory in lock-step.
- Counts mismatches, records the first failing address and raises done/pass.
- Parametrised successor to the fixed 21-bit / 1024-word software compare loop. Word width, depth, memory read latency and sweep length are configurable, and the result is available on-chip rather than only in simulation.

Parameters:
- DATA_W, 21, width of result and golden words.
- ADDR_W, 10, memory address width; max depth is 2**ADDR_W words.
- RD_LAT, 1, read latency in cycles of both memories (1..4); read data is valid RD_LAT cycles after rd_en.
- CNT_W, 16, width of the mismatch counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin a sweep; ignored while busy.
- len  in  ADDR_W+1  number of words to check; sampled when start is accepted.
- rd_en  out  1  read strobe to both memories.
- rd_addr  out  ADDR_W  shared read address.
- dut_data  in  DATA_W  read data from the result memory.
- gold_data  in  DATA_W  read data from the golden memory.
- busy  out  1  high while in ISSUE or DRAIN.
- done  out  1  level; high in DONE until the next accepted start.
- pass  out  1  valid when done=1; 1 iff err_cnt==0.
- err_cnt  out  CNT_W  mismatch count; saturates at all-ones.
- first_err_addr  out  ADDR_W  address of the first mismatch.
- first_err_vld  out  1  high once any mismatch has been recorded.

Behaviour:
- Reset (rst=0 at a clk edge) has priority over everything, including mid-sweep.
  - State returns to IDLE.
  - All outputs go to 0: rd_en, rd_addr, busy, done, pass, err_cnt, first_err_addr, first_err_vld.
  - The RD_LAT-deep valid pipeline is flushed.
- FSM states are IDLE, ISSUE, DRAIN and DONE.
- Accepting start: start=1 sampled in IDLE or DONE.
  - Latches len, clears err_cnt and first_err_vld/addr, drops done and pass.
  - With len!=0, enters ISSUE.
  - With len==0, goes straight to DONE with pass=1 and err_cnt=0; no reads are issued.
- ISSUE:
  - rd_en=1 for exactly len consecutive cycles, with rd_addr = 0,1,...,len-1.
  - After the read at address len-1, moves to DRAIN.
- DRAIN:
  - Holds rd_en=0 until the RD_LAT in-flight reads have returned, then moves to DONE.
- Compare pipeline:
  - A shift register of rd_en/rd_addr, RD_LAT deep, marks valid data.
  - On a valid cycle, mismatch = (dut_data != gold_data), over the full DATA_W bits.
  - On mismatch: err_cnt increments, saturating at 2**CNT_W-1.
  - If first_err_vld=0, first_err_addr takes the delayed address and first_err_vld is set. Later mismatches do not change first_err_addr.
- Latency: with start accepted at edge T, rd_en is high in cycles T+1..T+len.
  - The last compare occurs in cycle T+len+RD_LAT.
  - done=1 and a valid pass from cycle T+len+RD_LAT+1.
- start while busy is ignored and does not restart or extend the sweep.
- start in DONE begins a new sweep with cleared results, as above.
- len > 2**ADDR_W is clamped to 2**ADDR_W.

Optional Feature:
- Macro CHK_TOLERANCE_EN.
- Defined:
  - Adds input port tol [DATA_W-1:0], sampled at start.
  - mismatch = |dut_data - gold_data| > tol, computed as an unsigned absolute difference.
  - tol=0 is equivalent to exact compare.
- Undefined:
  - No tol port; exact bitwise compare only.

Test Plan:
- Reset mid-sweep:
  - Stimulus: start with len=1024, assert rst=0 at rd_addr=300, release, then issue start with len=4 on matching data.
  - Required: outputs 0 during reset; the second sweep finishes with done=1, pass=1, err_cnt=0.
- Full clean sweep:
  - Stimulus: len=1024, RD_LAT=1, memories identical.
  - Required: rd_en high exactly 1024 cycles; done rises at T+1026; pass=1, err_cnt=0, first_err_vld=0.
- Injected errors:
  - Stimulus: gold word differs at addresses 5, 17 and 1023.
  - Required: err_cnt=3, first_err_addr=5, first_err_vld=1, pass=0.
- Edge lengths and ignored start:
  - Stimulus: len=0, then len=1 with a mismatch at address 0, with a second start pulsed mid-sweep on a len=16 run.
  - Required: len=0 gives done at T+1 with pass=1; len=1 gives err_cnt=1, first_err_addr=0; the mid-sweep start is ignored.
- Latency and saturation:
  - Stimulus: RD_LAT=3 with CNT_W=4 and all 32 words mismatching.
  - Required: done at T+32+4; err_cnt saturates at 15; first_err_addr=0.
- Tolerance (CHK_TOLERANCE_EN defined):
  - Stimulus: tol=2; word pairs (100,102), (100,97), (0,3).
  - Required: only the last two count; err_cnt=2.
